// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS controller:
// state enum, opcode/funct constants, ALU and mux select encodings.
package mips_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_RTYPE_EX,
    S_RTYPE_WB,
    S_BR_EX,
    S_ADDI_EX,
    S_ADDI_WB,
    S_J_EX,
    S_TRAP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that hold mem_req and are subject to the wait-state timeout.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// R-type funct decoder: funct -> alu_control, plus illegal flag.
// Ports: funct (in 6), alu_control (out 4), illegal (out 1).
module mips_mc_alu_decoder
  import mips_mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic       illegal
);

  always_comb begin
    alu_control = ALU_AND;
    illegal     = 1'b0;
    unique case (funct)
      F_ADD:   alu_control = ALU_ADD;
      F_SUB:   alu_control = ALU_SUB;
      F_AND:   alu_control = ALU_AND;
      F_OR:    alu_control = ALU_OR;
      F_SLT:   alu_control = ALU_SLT;
      F_NOR:   alu_control = ALU_NOR;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multi-cycle MIPS control FSM with req/ready memory, timeout trap, retire count.
// Ports: clk, reset, op, funct, zero, mem_ready in; datapath controls, instr_done, retired, fault out.
module mips_mc_control
  import mips_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32,
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_en,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_control,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired,
  output logic             fault
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t            state;
  state_t            state_nx;
  logic [WAIT_W-1:0] wait_cnt;
  logic [3:0]        alu_dec;
  logic              funct_bad;
  logic              in_mem;
  logic              timeout;

  mips_mc_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_control (alu_dec),
    .illegal     (funct_bad)
  );

  assign in_mem = is_mem_state(state);

  // Last unanswered cycle allowed: this one completes the count.
  assign timeout = in_mem && !mem_ready &&
                   (wait_cnt >= WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: begin
        if (mem_ready)    state_nx = S_DECODE;
        else if (timeout) state_nx = S_TRAP;
      end
      S_DECODE: begin
        unique case (1'b1)
          (op == OP_LW) || (op == OP_SW): state_nx = S_MEMADR;
          (op == OP_RTYPE): state_nx = S_RTYPE_EX;
          (op == OP_BEQ):   state_nx = S_BR_EX;
          (op == OP_BNE):
            state_nx = SUPPORT_BNE ? S_BR_EX : S_TRAP;
          (op == OP_ADDI):  state_nx = S_ADDI_EX;
          (op == OP_J):     state_nx = S_J_EX;
          default:          state_nx = S_TRAP;
        endcase
      end
      S_MEMADR:
        state_nx = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem_ready)    state_nx = S_MEM_WB;
        else if (timeout) state_nx = S_TRAP;
      end
      S_MEM_WR: begin
        if (mem_ready)    state_nx = S_FETCH;
        else if (timeout) state_nx = S_TRAP;
      end
      S_RTYPE_EX:
        state_nx = funct_bad ? S_TRAP : S_RTYPE_WB;
      S_ADDI_EX: state_nx = S_ADDI_WB;
      S_MEM_WB,
      S_RTYPE_WB,
      S_BR_EX,
      S_ADDI_WB,
      S_J_EX:    state_nx = S_FETCH;
      S_TRAP:    state_nx = S_TRAP;
      default:   state_nx = S_TRAP;
    endcase
  end

  // Reset forces every output to 0 combinationally so nothing
  // fires in the cycle an outstanding access is abandoned.
  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_en       = 1'b0;
    pc_src      = PCSRC_ALU;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_RT;
    alu_control = 4'b0000;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    instr_done  = 1'b0;
    fault       = 1'b0;
    if (!reset) begin
      unique case (state)
        S_FETCH: begin
          mem_req     = 1'b1;
          alu_src_b   = SRCB_FOUR;
          alu_control = ALU_ADD;
          ir_write    = mem_ready;
          pc_en       = mem_ready;
        end
        S_DECODE: begin
          alu_src_b   = SRCB_IMM_SH;
          alu_control = ALU_ADD;
        end
        S_MEMADR: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
        end
        S_MEM_RD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_req    = 1'b1;
          mem_write  = 1'b1;
          iord       = 1'b1;
          instr_done = mem_ready;
        end
        S_RTYPE_EX: begin
          alu_src_a   = 1'b1;
          alu_control = alu_dec;
        end
        S_RTYPE_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BR_EX: begin
          alu_src_a   = 1'b1;
          alu_control = ALU_SUB;
          pc_src      = PCSRC_ALUOUT;
          pc_en       = (op == OP_BNE) ? ~zero : zero;
          instr_done  = 1'b1;
        end
        S_ADDI_EX: begin
          alu_src_a   = 1'b1;
          alu_src_b   = SRCB_IMM;
          alu_control = ALU_ADD;
        end
        S_ADDI_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_J_EX: begin
          pc_src     = PCSRC_JUMP;
          pc_en      = 1'b1;
          instr_done = 1'b1;
        end
        S_TRAP:  fault = 1'b1;
        default: fault = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= state_nx;
      // Count only while lingering in the same memory state.
      if (in_mem && !mem_ready && state_nx == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (instr_done)
        retired <= retired + 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_mc_control.sv
// Directed scoreboard bench for mips_mc_control.
// Two instances: default params (a) and MEM_TIMEOUT=4/CNT_W=4/no bne (b).
`define CHK(tag, o, e) chk(tag, 32'(o), 32'(e))
module tb_mips_mc_control;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [5:0] op = OP_J;
  logic [5:0] funct = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic mem_req_a, mem_write_a, iord_a, ir_write_a, pc_en_a;
  logic alu_src_a_a, reg_dst_a, mem_to_reg_a, reg_write_a;
  logic instr_done_a, fault_a;
  logic [1:0] pc_src_a, alu_src_b_a;
  logic [3:0] alu_control_a;
  logic [31:0] retired_a;

  logic mem_req_b, mem_write_b, iord_b, ir_write_b, pc_en_b;
  logic alu_src_a_b, reg_dst_b, mem_to_reg_b, reg_write_b;
  logic instr_done_b, fault_b;
  logic [1:0] pc_src_b, alu_src_b_b;
  logic [3:0] alu_control_b;
  logic [3:0] retired_b;

  logic [5:0]  en_a, en_b;
  logic [11:0] sel_a, sel_b;
  assign en_a = {mem_req_a, mem_write_a, ir_write_a,
                 pc_en_a, reg_write_a, instr_done_a};
  assign en_b = {mem_req_b, mem_write_b, ir_write_b,
                 pc_en_b, reg_write_b, instr_done_b};
  assign sel_a = {pc_src_a, alu_src_a_a, alu_src_b_a,
                  alu_control_a, reg_dst_a, mem_to_reg_a, iord_a};
  assign sel_b = {pc_src_b, alu_src_a_b, alu_src_b_b,
                  alu_control_b, reg_dst_b, mem_to_reg_b, iord_b};

  mips_mc_control dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_a), .mem_write(mem_write_a),
    .iord(iord_a), .ir_write(ir_write_a), .pc_en(pc_en_a),
    .pc_src(pc_src_a), .alu_src_a(alu_src_a_a),
    .alu_src_b(alu_src_b_a), .alu_control(alu_control_a),
    .reg_dst(reg_dst_a), .mem_to_reg(mem_to_reg_a),
    .reg_write(reg_write_a), .instr_done(instr_done_a),
    .retired(retired_a), .fault(fault_a)
  );

  mips_mc_control #(
    .MEM_TIMEOUT(4), .CNT_W(4), .SUPPORT_BNE(1'b0)
  ) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req_b), .mem_write(mem_write_b),
    .iord(iord_b), .ir_write(ir_write_b), .pc_en(pc_en_b),
    .pc_src(pc_src_b), .alu_src_a(alu_src_a_b),
    .alu_src_b(alu_src_b_b), .alu_control(alu_control_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b),
    .reg_write(reg_write_b), .instr_done(instr_done_b),
    .retired(retired_b), .fault(fault_b)
  );

  int n_cmp = 0;
  int n_err = 0;

  always @(posedge clk) begin
    if (reset) begin
      n_cmp++;
      if ({en_a, en_b} !== 12'b0) begin
        n_err++;
        $error("FAIL mon_rst_en: observed %0h", {en_a, en_b});
      end
    end
    n_cmp++;
    if ({mem_write_a & ~mem_req_a, mem_write_b & ~mem_req_b}
        !== 2'b00) begin
      n_err++;
      $error("FAIL mon_wr_req: write without req");
    end
  end

  typedef struct {
    int          cycles;
    logic [31:0] ret;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model_ret_a = '0;
  int          total_cyc;
  int          last_cyc;
  logic        last_pc_en, last_reg_write;
  logic        last_reg_dst, last_mem_to_reg;
  logic [1:0]  last_pc_src;
  logic [3:0]  last_alu;

  logic [5:0] fn_tab [6] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR};
  logic [3:0] ac_tab [6] = '{ALU_ADD, ALU_SUB, ALU_AND,
                             ALU_OR, ALU_SLT, ALU_NOR};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      `CHK("rst_en_a", en_a, 6'b0);
      `CHK("rst_sel_a", sel_a, 12'b0);
      `CHK("rst_fault_a", fault_a, 1'b0);
      `CHK("rst_en_b", en_b, 6'b0);
      `CHK("rst_sel_b", sel_b, 12'b0);
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    `CHK("rel_fault", {fault_a, fault_b}, 2'b00);
    `CHK("rel_ret_a", retired_a, 32'd0);
    `CHK("rel_ret_b", retired_b, 4'd0);
    `CHK("rel_fetch", {mem_req_a, iord_a, alu_src_b_a}, 4'b1001);
    model_ret_a = '0;
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                           input logic z, input int delay);
    op = o;
    funct = f;
    zero = z;
    last_cyc = -1;
    for (int c = 0; c < 64; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = (c >= delay);
      #1;
      if (c == delay + 2) last_alu = alu_control_a;
      if (delay > 0 && c <= delay)
        `CHK("fetch_strobe", {ir_write_a, pc_en_a},
             (c == delay) ? 2'b11 : 2'b00);
      if (instr_done_a) begin
        last_cyc        = c + 1;
        last_pc_en      = pc_en_a;
        last_pc_src     = pc_src_a;
        last_reg_write  = reg_write_a;
        last_reg_dst    = reg_dst_a;
        last_mem_to_reg = mem_to_reg_a;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic instr(input string tag, input logic [5:0] o,
                       input logic [5:0] f, input logic z,
                       input int delay, input int exp_cyc);
    exp_t e;
    model_ret_a = model_ret_a + 1;
    e.cycles = exp_cyc;
    e.ret = model_ret_a;
    sb.push_back(e);
    run_instr(o, f, z, delay);
    e = sb.pop_front();
    `CHK(tag, last_cyc, e.cycles);
    `CHK("retired_a", retired_a, e.ret);
    total_cyc += last_cyc;
  endtask

  initial begin
    @(negedge clk);
    do_reset(2);

    op = OP_LW;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    `CHK("in_mem_rd", {mem_req_a, iord_a, mem_write_a}, 3'b110);
    @(negedge clk);
    do_reset(3);

    total_cyc = 0;
    instr("addi_cyc", OP_ADDI, 6'b0, 1'b0, 0, 4);
    `CHK("addi_wb", {last_reg_write, last_reg_dst, last_mem_to_reg},
         3'b100);
    instr("add_cyc", OP_RTYPE, F_ADD, 1'b0, 0, 4);
    `CHK("add_wb", {last_reg_write, last_reg_dst, last_mem_to_reg},
         3'b110);
    instr("lw_cyc", OP_LW, 6'b0, 1'b0, 0, 5);
    `CHK("lw_wb", {last_reg_write, last_reg_dst, last_mem_to_reg},
         3'b101);
    instr("sw_cyc", OP_SW, 6'b0, 1'b0, 0, 4);
    instr("beq_cyc", OP_BEQ, 6'b0, 1'b1, 0, 3);
    `CHK("beq_pc", {last_pc_en, last_pc_src}, 3'b101);
    instr("j_cyc", OP_J, 6'b0, 1'b0, 0, 3);
    `CHK("j_pc", {last_pc_en, last_pc_src}, 3'b110);
    `CHK("seq_cycles", total_cyc, 23);
    `CHK("seq_retired", retired_a, 32'd6);

    instr("bne_cyc", OP_BNE, 6'b0, 1'b1, 0, 3);
    `CHK("bne_z1_pc_en", last_pc_en, 1'b0);
    `CHK("bne_b_fault", fault_b, 1'b1);
    instr("bne0_cyc", OP_BNE, 6'b0, 1'b0, 0, 3);
    `CHK("bne_z0_pc_en", last_pc_en, 1'b1);

    for (int i = 0; i < 6; i++) begin
      instr("rtype_cyc", OP_RTYPE, fn_tab[i], 1'b0, 0, 4);
      `CHK("alu_ctl", last_alu, ac_tab[i]);
    end
    do_reset(1);

    instr("j_slow_cyc", OP_J, 6'b0, 1'b0, 5, 8);
    do_reset(1);

    op = OP_SW;
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      `CHK("wr_wait", {mem_req_b, mem_write_b, iord_b,
                       instr_done_b, fault_b}, 5'b11100);
    end
    @(negedge clk);
    #1;
    `CHK("wr_trap_fault", fault_b, 1'b1);
    `CHK("wr_trap_en", en_b, 6'b0);
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    `CHK("late_ready", {fault_b, en_b}, 7'b1000000);
    `CHK("late_ret", retired_b, 4'd0);
    @(negedge clk);
    do_reset(1);

    op = OP_RTYPE;
    funct = 6'b111111;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      `CHK("bad_funct_wr", {reg_write_a, instr_done_a}, 2'b00);
    end
    `CHK("bad_funct_fault", fault_a, 1'b1);
    `CHK("bad_funct_ret", retired_a, 32'd0);
    @(negedge clk);
    do_reset(1);

    for (int i = 0; i < 15; i++)
      instr("j_wrap_cyc", OP_J, 6'b0, 1'b0, 0, 3);
    `CHK("wrap_pre", retired_b, 4'hF);
    instr("j_wrap_cyc", OP_J, 6'b0, 1'b0, 0, 3);
    `CHK("wrap_post", retired_b, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multi-cycle MIPS control unit: the successor to the single-cycle controller, for a datapath with one shared instruction/data memory.
- A Moore state machine sequences fetch, decode, execute, memory and writeback over several cycles.
- Memory is accessed through a req/ready handshake with a configurable wait-state timeout.
- Adds a sticky fault/trap state and a retired-instruction counter. Sits between the instruction register/ALU flags and the multi-cycle datapath plus unified memory.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles mem_req may stay unanswered before trapping. Must be ≥1.
- CNT_W, 32: width of the retired-instruction counter.
- SUPPORT_BNE, 1: 1 decodes bne (000101); 0 treats it as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  6  Instr[31:26] from instruction register
- funct  in  6  Instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  access is a write (valid only with mem_req)
- iord  out  1  0 = address is PC, 1 = address is ALUOut
- ir_write  out  1  load instruction register
- pc_en  out  1  PC write enable
- pc_src  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_src_a  out  1  0 = PC, 1 = rs register
- alu_src_b  out  2  00 rt, 01 const 4, 10 signext imm, 11 signext imm<<2
- alu_control  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = memory data register, 0 = ALUOut
- reg_write  out  1  register file write enable
- instr_done  out  1  one-cycle pulse when an instruction retires
- retired  out  CNT_W  retired-instruction count, wraps modulo 2^CNT_W
- fault  out  1  sticky trap indicator

Behaviour:
- Reset: synchronous reset is active-high. While reset=1, every enable/strobe output is 0 (mem_req, mem_write, ir_write, pc_en, reg_write, instr_done). Mux selects and alu_control are 0, fault=0. On the edge: state←FETCH, retired←0, wait counter←0.
- Reset mid-operation: an outstanding access is abandoned; no write enable fires in the reset cycle.
- Outputs are decoded from the current state only. Exceptions are the ready-qualified strobes (ir_write, pc_en, instr_done in memory states) and pc_en in branch states, which also depend on mem_ready/zero in the same cycle.
- States and transitions:
  - FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00. On mem_ready: ir_write=1, pc_en=1, go to DECODE; else stay.
  - DECODE: alu_src_a=0, alu_src_b=11, add (branch target → ALUOut). Next state by op:
    - 100011/101011 → MEMADR
    - 000000 → RTYPE_EX
    - 000100 → BR_EX
    - 000101 → BR_EX if SUPPORT_BNE, else TRAP
    - 001000 → ADDI_EX
    - 000010 → J_EX
    - other → TRAP
  - MEMADR: alu_src_a=1, alu_src_b=10, add. lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: mem_req=1, iord=1. On ready → MEM_WB.
  - MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1 → FETCH.
  - MEM_WR: mem_req=1, mem_write=1, iord=1. On ready: instr_done=1 → FETCH.
  - RTYPE_EX: alu_src_a=1, alu_src_b=00, alu_control from funct:
    - 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 100111 nor
    - any other funct → TRAP, no writeback
    - valid funct → RTYPE_WB
  - RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1 → FETCH.
  - BR_EX: alu_src_a=1, alu_src_b=00, sub, pc_src=01. pc_en=zero for beq, ~zero for bne. instr_done=1 → FETCH.
  - ADDI_EX: alu_src_a=1, alu_src_b=10, add → ADDI_WB.
  - ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1 → FETCH.
  - J_EX: pc_src=10, pc_en=1, instr_done=1 → FETCH.
  - TRAP: all enables 0, fault=1. Terminal until reset.
- Wait counter:
  - Cleared on entering any memory state and whenever mem_ready=1.
  - Increments each cycle in a memory state with mem_ready=0.
  - If it reaches MEM_TIMEOUT while ready is still 0 → TRAP next edge. No PC, IR or register write occurs on that path.
  - mem_ready outside a memory state is ignored.
- Counter and latency:
  - retired increments on every instr_done cycle. Wrap-around from all-ones to 0 is silent.
  - With zero-wait memory: lw=5 cycles, sw/R-type/addi=4, beq/bne/j=3.

Decomposition:
- Shared package mips_mc_pkg holds:
  - state enum
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - ALU control encodings
  - alu_src_b and pc_src select encodings
- One natural sub-module: mips_mc_alu_decoder (funct → alu_control plus illegal flag), purely combinational.

Test Plan:
- Reset held 3 cycles mid-MEM_RD → all enables 0 during reset; state=FETCH, retired=0, fault=0 after release.
- Zero-wait sequence addi, add(funct 100000), lw, sw, beq(zero=1), j → retired=6 after 3+... exactly 4+4+5+4+3+3=23 cycles. Each instr_done lands on the expected cycle; beq produces pc_en=1 with pc_src=01.
- bne with zero=1 → pc_en=0 in BR_EX. Same op with SUPPORT_BNE=0 → fault=1 after DECODE.
- FETCH with mem_ready delayed 5 cycles (MEM_TIMEOUT=16) → ir_write/pc_en pulse only on the ready cycle, never earlier.
- MEM_WR with mem_ready held 0 and MEM_TIMEOUT=4 → TRAP after 4 wait cycles; fault=1 and no instr_done. A later mem_ready pulse has no effect.
- R-type with funct 111111 → TRAP with no reg_write. CNT_W=4, preset by 15 retirements, then one more → retired wraps to 0.
